// File: rtl/run_step_ctrl_if.sv
// run_step_ctrl_if: front-panel / processor-control bundle for run_step_ctrl.
//   btn_step   : raw bouncing step push-button (asynchronous)
//   sw_run     : raw run-mode slide switch (asynchronous)
//   halt_req   : synchronous halt request from the processor
//   cpu_tick   : one-cycle processor clock-enable pulse
//   mode       : 00 IDLE, 01 RUN, 10 HALTED
//   tick_count : cpu_tick pulses issued since reset (wraps)
// master drives the controls (board/bench); slave is the controller.
interface run_step_ctrl_if;
   logic        btn_step;
   logic        sw_run;
   logic        halt_req;
   logic        cpu_tick;
   logic [1:0]  mode;
   logic [15:0] tick_count;

   modport master (
      output btn_step, sw_run, halt_req,
      input  cpu_tick, mode, tick_count
   );

   modport slave (
      input  btn_step, sw_run, halt_req,
      output cpu_tick, mode, tick_count
   );
endinterface

// File: rtl/run_step_ctrl.sv
// run_step_ctrl: single-step / free-run clock-enable generator for a soft CPU.
// A debounced step button issues one cpu_tick in IDLE; the run switch selects
// a divided periodic tick; halt_req parks the block in HALTED until the run
// switch is turned off.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : run_step_ctrl_if.slave (btn_step, sw_run, halt_req in;
//           cpu_tick, mode, tick_count out, all registered)
module run_step_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned RUN_DIV         = 100000000
) (
   input  logic           clk,
   input  logic           reset,
   run_step_ctrl_if.slave bus
);

   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int unsigned DIV_W = $clog2(RUN_DIV) + 1;
   localparam int unsigned CNT_W = 16;

   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   // Encoding doubles as the mode output.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      HALTED = 2'b10
   } state_t;

   logic             btn_s1;
   logic             btn_s2;
   logic             sw_s1;
   logic             sw_s2;
   logic             db_state;
   logic             db_prev;
   logic [DB_W-1:0]  db_cnt;
   logic [DIV_W-1:0] div_cnt;
   state_t           state;
   logic             cpu_tick;
   logic [CNT_W-1:0] tick_cnt;
   logic             step_evt_c;

   // Two-flop synchronizers; nothing else touches the raw inputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1 <= 1'b0;
         btn_s2 <= 1'b0;
         sw_s1  <= 1'b0;
         sw_s2  <= 1'b0;
      end else begin
         btn_s1 <= bus.btn_step;
         btn_s2 <= btn_s1;
         sw_s1  <= bus.sw_run;
         sw_s2  <= sw_s1;
      end
   end

   // Debouncer: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_state <= 1'b0;
         db_prev  <= 1'b0;
         db_cnt   <= '0;
      end else begin
         db_prev <= db_state;
         if (btn_s2 != db_state) begin
            if (db_cnt == DB_LAST) begin
               db_state <= btn_s2;
               db_cnt   <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   // Rising edge of the debounced level, taken between two registers.
   assign step_evt_c = db_state & ~db_prev;

   // Mode FSM with divider and tick counter; halt_req outranks everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cpu_tick <= 1'b0;
         div_cnt  <= '0;
         tick_cnt <= '0;
      end else begin
         cpu_tick <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.halt_req) begin
                  state <= HALTED;
               end else if (sw_s2) begin
                  // Entering RUN drops any coincident step event.
                  state   <= RUN;
                  div_cnt <= '0;
               end else if (step_evt_c) begin
                  cpu_tick <= 1'b1;
                  tick_cnt <= tick_cnt + CNT_W'(1);
               end
            end
            RUN: begin
               if (bus.halt_req) begin
                  state   <= HALTED;
                  div_cnt <= '0;
               end else if (!sw_s2) begin
                  state   <= IDLE;
                  div_cnt <= '0;
               end else if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  cpu_tick <= 1'b1;
                  tick_cnt <= tick_cnt + CNT_W'(1);
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            HALTED: begin
               if (!sw_s2 && !bus.halt_req) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_tick   = cpu_tick;
   assign bus.mode       = state;
   assign bus.tick_count = tick_cnt;

endmodule

// File: tb/tb_run_step_ctrl.sv
// tb_run_step_ctrl: directed bench for run_step_ctrl with a cycle-level
// reference model (input history, sliding debounce window, run-age ticks)
// checked every cycle, plus literal latency/count expectations.
module tb_run_step_ctrl;

   localparam int unsigned DEB = 4;
   localparam int unsigned DIV = 5;

   logic clk = 1'b0;
   logic reset;

   run_step_ctrl_if bus ();

   run_step_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .RUN_DIV        (DIV)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   int unsigned cyc = 0;
   logic        model_valid = 1'b0;
   logic [1:0]  m_mode;
   logic        m_tick;
   logic [15:0] m_cnt;
   logic        sw_h  [2];
   logic        btn_h [2];
   logic        win   [DEB];
   logic        db_level;
   logic        rose_prev;
   int unsigned age;
   int          preload_req = 0;
   int          preload_seen = 0;

   int n_cmp = 0;
   int n_bad = 0;
   int ticks[$];

   // Model: evaluates the rules at each rising edge from the input history.
   always @(posedge clk) begin
      logic sw_sync;
      logic btn_sync;
      logic step;
      logic all_diff;
      cyc = cyc + 1;
      if (preload_seen != preload_req) begin
         m_cnt        = 16'hFFFF;
         preload_seen = preload_req;
      end
      if (reset) begin
         m_mode    = 2'd0;
         m_tick    = 1'b0;
         m_cnt     = 16'd0;
         sw_h[0]   = 1'b0;
         sw_h[1]   = 1'b0;
         btn_h[0]  = 1'b0;
         btn_h[1]  = 1'b0;
         for (int i = 0; i < int'(DEB); i++) win[i] = 1'b0;
         db_level  = 1'b0;
         rose_prev = 1'b0;
         age       = 0;
         model_valid = 1'b1;
      end else begin
         // Values seen two edges late through the synchronizer
         sw_sync  = sw_h[1];
         btn_sync = btn_h[1];
         step     = rose_prev;
         for (int i = int'(DEB) - 1; i > 0; i--) win[i] = win[i-1];
         win[0] = btn_sync;
         all_diff = 1'b1;
         for (int i = 0; i < int'(DEB); i++) if (win[i] == db_level) all_diff = 1'b0;
         rose_prev = 1'b0;
         if (all_diff) begin
            db_level  = btn_sync;
            rose_prev = btn_sync;
         end
         sw_h[1]  = sw_h[0];
         sw_h[0]  = bus.sw_run;
         btn_h[1] = btn_h[0];
         btn_h[0] = bus.btn_step;

         m_tick = 1'b0;
         case (m_mode)
            2'd0: begin
               if (bus.halt_req) m_mode = 2'd2;
               else if (sw_sync) begin
                  m_mode = 2'd1;
                  age    = 0;
               end else if (step) begin
                  m_tick = 1'b1;
                  m_cnt  = m_cnt + 16'd1;
               end
            end
            2'd1: begin
               age = age + 1;
               if (bus.halt_req) m_mode = 2'd2;
               else if (!sw_sync) m_mode = 2'd0;
               else if (age % DIV == 0) begin
                  m_tick = 1'b1;
                  m_cnt  = m_cnt + 16'd1;
               end
            end
            default: begin
               if (!sw_sync && !bus.halt_req) m_mode = 2'd0;
            end
         endcase
      end
   end

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Per-cycle comparison against the model, and tick logging.
   task automatic compare_loop();
      forever begin
         @(negedge clk);
         if (bus.cpu_tick === 1'b1) ticks.push_back(int'(cyc));
         if (model_valid) begin
            n_cmp++;
            if (bus.cpu_tick !== m_tick || bus.mode !== m_mode || bus.tick_count !== m_cnt) begin
               n_bad++;
               $display("FAIL cycle_model cyc=%0d: got tick=%b mode=%b cnt=%h, expected tick=%b mode=%b cnt=%h",
                        cyc, bus.cpu_tick, bus.mode, bus.tick_count, m_tick, m_mode, m_cnt);
            end
         end
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic int tick_at(input int idx);
      if (idx < ticks.size()) return ticks[idx];
      return -1000;
   endfunction

   initial begin
      int t0;
      int mark;
      fork
         compare_loop();
      join_none

      reset        = 1'b1;
      bus.btn_step = 1'b0;
      bus.sw_run   = 1'b0;
      bus.halt_req = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_tick", int'(bus.cpu_tick), 0);
      check("reset_mode", int'(bus.mode), 0);
      check("reset_count", int'(bus.tick_count), 0);
      reset = 1'b0;

      // Single step: one tick 7 cycles after the press, none on release
      repeat (3) @(negedge clk);
      mark = ticks.size();
      t0 = int'(cyc);
      bus.btn_step = 1'b1;
      repeat (20) @(negedge clk);
      bus.btn_step = 1'b0;
      repeat (15) @(negedge clk);
      check("step_ticks", ticks.size() - mark, 1);
      check("step_latency", tick_at(mark) - t0, 7);
      check("step_count", int'(bus.tick_count), 1);

      // Bounce rejection: 2 high / 2 low x5
      pulse_reset();
      mark = ticks.size();
      repeat (5) begin
         bus.btn_step = 1'b1;
         repeat (2) @(negedge clk);
         bus.btn_step = 1'b0;
         repeat (2) @(negedge clk);
      end
      repeat (15) @(negedge clk);
      check("bounce_ticks", ticks.size() - mark, 0);
      check("bounce_count", int'(bus.tick_count), 0);

      // Run mode for 30 cycles
      pulse_reset();
      mark = ticks.size();
      t0 = int'(cyc);
      bus.sw_run = 1'b1;
      repeat (2) @(negedge clk);
      check("run_mode_early", int'(bus.mode), 0);
      @(negedge clk);
      check("run_mode_entry", int'(bus.mode), 1);
      repeat (27) @(negedge clk);
      bus.sw_run = 1'b0;
      repeat (15) @(negedge clk);
      check("run_ticks", ticks.size() - mark, 5);
      check("run_first", tick_at(mark) - t0, 8);
      check("run_span", tick_at(mark + 4) - tick_at(mark), 20);
      check("run_exit_mode", int'(bus.mode), 0);
      check("run_count", int'(bus.tick_count), 5);

      // Halt from RUN
      pulse_reset();
      bus.sw_run = 1'b1;
      repeat (10) @(negedge clk);
      mark = ticks.size();
      bus.halt_req = 1'b1;
      @(negedge clk);
      check("halt_mode", int'(bus.mode), 2);
      bus.halt_req = 1'b0;
      repeat (10) @(negedge clk);
      check("halt_hold_mode", int'(bus.mode), 2);
      check("halt_ticks", ticks.size() - mark, 0);
      bus.sw_run = 1'b0;
      repeat (4) @(negedge clk);
      check("halt_exit_mode", int'(bus.mode), 0);

      // Wrap: preload 0xFFFF then one step
      pulse_reset();
      #2;
      force dut.tick_cnt = 16'hFFFF;
      preload_req = preload_req + 1;
      @(negedge clk);
      #2;
      release dut.tick_cnt;
      @(negedge clk);
      check("wrap_preload", int'(bus.tick_count), 16'hFFFF);
      mark = ticks.size();
      bus.btn_step = 1'b1;
      repeat (12) @(negedge clk);
      check("wrap_ticks", ticks.size() - mark, 1);
      check("wrap_count", int'(bus.tick_count), 0);

      // Button already high across reset: one step after debounce
      reset = 1'b1;
      repeat (3) @(negedge clk);
      mark = ticks.size();
      t0 = int'(cyc);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      check("held_ticks", ticks.size() - mark, 1);
      check("held_latency", tick_at(mark) - t0, 7);
      bus.btn_step = 1'b0;

      // Reset mid-RUN, three cycles after a tick
      pulse_reset();
      repeat (8) @(negedge clk);
      mark = ticks.size();
      bus.sw_run = 1'b1;
      for (int i = 0; i < 20 && ticks.size() == mark; i++) @(negedge clk);
      check("rst_pre_tick", ticks.size() - mark, 1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_tick", int'(bus.cpu_tick), 0);
      check("rst_mode", int'(bus.mode), 0);
      check("rst_count", int'(bus.tick_count), 0);
      reset = 1'b0;
      t0 = int'(cyc);
      mark = ticks.size();
      repeat (12) @(negedge clk);
      check("rerun_first", tick_at(mark) - t0, 8);
      check("rerun_mode", int'(bus.mode), 1);
      bus.sw_run = 1'b0;
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/run_step_ctrl.md
RUN_STEP_CTRL -- requirements
Module: run_step_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable samples needed to accept a new button level (10 ms at 100 MHz).
REQ-002 Parameter RUN_DIV, default 100000000: clk cycles between ticks in RUN mode (1 Hz at 100 MHz).
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_step  input  1  raw, asynchronous, bouncing step push-button.
REQ-006 sw_run  input  1  raw, asynchronous run-mode slide switch.
REQ-007 halt_req  input  1  synchronous halt request from the processor (for example, end of program).
REQ-008 cpu_tick  output  1  one-cycle advance pulse; the processor clock enable.
REQ-009 mode  output  2  00 IDLE, 01 RUN, 10 HALTED; 11 never driven.
REQ-010 tick_count  output  16  number of cpu_tick pulses issued since reset.

Function
REQ-011 btn_step and sw_run SHALL each pass through a 2-flop synchronizer; no other logic samples the raw inputs.
REQ-012 Debouncer: while the synchronized button differs from db_state, counter increments; otherwise counter clears to 0.
REQ-013 When the counter is DEBOUNCE_CYCLES-1 and the sample still differs, db_state SHALL take the sample and the counter SHALL clear; counter width is $clog2(DEBOUNCE_CYCLES)+1.
REQ-014 Step event = registered rising edge of db_state; a bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no event.
REQ-015 FSM states: IDLE, RUN, HALTED; encoding equals the mode output.
REQ-016 IDLE: a step event SHALL raise cpu_tick for exactly one cycle; synchronized sw_run=1 SHALL move to RUN.
REQ-017 RUN: the divider counter increments each cycle; at RUN_DIV-1 it SHALL raise cpu_tick for one cycle and wrap to 0.
REQ-018 RUN: step events are ignored, and synchronized sw_run=0 SHALL return to IDLE with the divider cleared and no tick that cycle.
REQ-019 RUN or IDLE: halt_req=1 SHALL move to HALTED with no tick that cycle; halt_req has priority over every other event.
REQ-020 HALTED: no ticks and step events ignored; leaves for IDLE only once synchronized sw_run=0 and halt_req=0.
REQ-021 The divider SHALL clear on every entry into RUN, so the first run tick comes exactly RUN_DIV cycles after entry.
REQ-022 Same-cycle step event and RUN entry: RUN wins and the step event is dropped.
REQ-023 tick_count SHALL increment on every cpu_tick and wrap 0xFFFF -> 0x0000.
REQ-024 cpu_tick, mode and tick_count SHALL be registered outputs.

Reset
REQ-025 reset=1 SHALL clear synchronizers, db_state, debounce and divider counters and tick_count, and force IDLE, cpu_tick=0 and mode=00 at the next edge.
REQ-026 Reset mid-debounce or mid-RUN SHALL discard pending state; after release the block behaves as if freshly started.
REQ-027 After reset release with btn_step already held high, the block SHALL issue one step event after debounce, not before.

Verification (DEBOUNCE_CYCLES=4, RUN_DIV=5)
REQ-028 Single step:
- Stimulus: IDLE, btn_step held high.
- Response: exactly one cpu_tick, 7 cycles after btn_step rises; tick_count=1; none on release.
REQ-029 Bounce rejection:
- Stimulus: btn_step pulses of 2 cycles high / 2 cycles low, repeated 5 times, then low.
- Response: no cpu_tick; tick_count=0.
REQ-030 Run mode:
- Stimulus: sw_run=1 held for 30 cycles.
- Response: mode=01 three cycles after sw_run rises.
- Response: ticks every 5 cycles, the first 5 cycles after entry.
- Response: sw_run=0 returns mode=00 with no further ticks.
REQ-031 Halt:
- Stimulus: in RUN, halt_req=1 for one cycle, then sw_run held at 1 for 10 cycles.
- Response: mode=10 and no ticks.
- Stimulus: then sw_run=0.
- Response: mode=00.
REQ-032 Wrap:
- Stimulus: preload tick_count to 0xFFFF by forcing, then one step event.
- Response: tick_count=0x0000.
REQ-033 Reset mid-RUN:
- Stimulus: reset=1 for one cycle, three cycles after a tick.
- Response: cpu_tick=0, mode=00 and tick_count=0 at the next edge.
- Response: with sw_run still 1, RUN resumes and the first tick comes 5 cycles after re-entry.
